gshare_bp: RTL and testbench

- Parametrised successor to the fetch-stage bimodal predictor.
- Pattern history table (PHT) of 2^IDX_W saturating counters, CNT_W bits each, indexed by PC XOR speculative global history register (GHR).
- Sits beside PC generation in IF. The predict side is combinational. Updates arrive from EX together with the GHR snapshot taken at predict time, so history can be repaired on a mispredict.
- Post-reset init sweep clears the table one entry per cycle, so the PHT maps onto a single-write-port array.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_pht.sv | 38 +++
 rtl/gshare_bp.sv | 103 ++++++++++
 tb/tb_gshare_bp.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants, state type and counter helpers for the branch predictor.
// Hashing mode is selected by BP_GSHARE_EN in gshare_bp (bimodal when undefined).
package bp_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic logic [3:0] wnt(input int unsigned cnt_w);
        return 4'((32'd1 << (cnt_w - 1)) - 32'd1);
    endfunction

    function automatic logic [3:0] sat_next(input logic [3:0] cnt, input logic taken,
                                            input int unsigned cnt_w);
        logic [3:0] cnt_max;
        cnt_max = 4'((32'd1 << cnt_w) - 32'd1);
        if (taken) begin
            return (cnt == cnt_max) ? cnt : cnt + 4'd1;
        end
        return (cnt == 4'd0) ? cnt : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: unreset counter array, async read, single sync write port.
// The write port either loads the init value or steps the addressed counter.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_en,
    input  logic             wr_init,
    input  logic             wr_taken,
    input  logic [IDX_W-1:0] wr_idx
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [CNT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wr_cnt;
    logic [3:0]       old_cnt;

    always_comb begin
        old_cnt = 4'(mem[wr_idx]);
        wr_cnt  = wr_init ? CNT_W'(wnt(CNT_W)) : CNT_W'(sat_next(old_cnt, wr_taken, CNT_W));
    end

    // No bypass: a same-cycle read sees the value before this write lands.
    assign rd_cnt = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_cnt;
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Fetch-stage branch predictor with speculative global history and repair.
// Define BP_GSHARE_EN for PC^GHR indexing; otherwise the PHT is indexed by PC alone.
module gshare_bp
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned GHR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic [5:0]       opcode,
    input  logic             fetch_valid,
    output logic             is_branch,
    output logic             branch_likely,
    output logic [GHR_W-1:0] pred_ghr,
    output logic             ready,
    input  logic             update,
    input  logic [31:0]      pc_update,
    input  logic [GHR_W-1:0] ghr_update,
    input  logic             branch_actual,
    input  logic             mispredict
);

    bp_state_e        state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [GHR_W-1:0] ghr_q;

    logic             run;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] pht_wr_idx;
    logic [CNT_W-1:0] rd_cnt;
    logic             unused_bits;

    assign run = (state_q == BP_RUN);

    always_comb begin
        case (opcode)
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
            default:                                     is_branch = 1'b0;
        endcase
    end

`ifdef BP_GSHARE_EN
    assign rd_idx = pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign wr_idx = pc_update[IDX_W+1:2] ^ IDX_W'(ghr_update);
`else
    assign rd_idx = pc[IDX_W+1:2];
    assign wr_idx = pc_update[IDX_W+1:2];
`endif

    assign unused_bits = ^{pc[31:IDX_W+2], pc[1:0], pc_update[31:IDX_W+2], pc_update[1:0],
                           ghr_update[GHR_W-1], rd_cnt[CNT_W-2:0]};

    // The sweep owns the write port until the table is initialised.
    assign pht_wr_idx = run ? wr_idx : ptr_q;

    bp_pht #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_pht (
        .clk      (clk),
        .rd_idx   (rd_idx),
        .rd_cnt   (rd_cnt),
        .wr_en    (run ? update : 1'b1),
        .wr_init  (~run),
        .wr_taken (branch_actual),
        .wr_idx   (pht_wr_idx)
    );

    assign ready         = run;
    assign branch_likely = is_branch & run & rd_cnt[CNT_W-1];
    assign pred_ghr      = ghr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BP_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            case (state_q)
                BP_INIT: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (&ptr_q) begin
                        state_q <= BP_RUN;
                    end
                end
                BP_RUN: begin
                    // Repair discards every younger speculative shift.
                    if (update && mispredict) begin
                        ghr_q <= {ghr_update[GHR_W-2:0], branch_actual};
                    end else if (fetch_valid && is_branch) begin
                        ghr_q <= {ghr_q[GHR_W-2:0], branch_likely};
                    end
                end
                default: state_q <= BP_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_bp.sv
// Self-checking bench for gshare_bp: decode table, directed corner sequences and
// randomized traffic against a counter-array reference model.
module tb_gshare_bp;

    localparam int IDX_W = 5;
    localparam int CNT_W = 2;
    localparam int GHR_W = 5;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int WNT   = 2 ** (CNT_W - 1) - 1;
    localparam int CMAX  = 2 ** CNT_W - 1;
    localparam int GMASK = 2 ** GHR_W - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      pc;
    logic [5:0]       opcode;
    logic             fetch_valid;
    logic             is_branch;
    logic             branch_likely;
    logic [GHR_W-1:0] pred_ghr;
    logic             ready;
    logic             update;
    logic [31:0]      pc_update;
    logic [GHR_W-1:0] ghr_update;
    logic             branch_actual;
    logic             mispredict;

    always #5 clk = ~clk;

    gshare_bp #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W),
        .GHR_W (GHR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .opcode        (opcode),
        .fetch_valid   (fetch_valid),
        .is_branch     (is_branch),
        .branch_likely (branch_likely),
        .pred_ghr      (pred_ghr),
        .ready         (ready),
        .update        (update),
        .pc_update     (pc_update),
        .ghr_update    (ghr_update),
        .branch_actual (branch_actual),
        .mispredict    (mispredict)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer counters, history as an integer.
    int m_pht[DEPTH];
    int m_ghr;
    int m_swept;
    bit m_ready;

    typedef struct {
        logic [5:0] op;
        bit         isb;
    } dec_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_is_branch(input logic [5:0] op);
        return op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
    endfunction

    function automatic int m_index(input logic [31:0] p, input int g);
`ifdef BP_GSHARE_EN
        return (int'(p >> 2) ^ g) % DEPTH;
`else
        return int'(p >> 2) % DEPTH;
`endif
    endfunction

    function automatic bit m_likely();
        if (!m_is_branch(opcode) || !m_ready) return 1'b0;
        return m_pht[m_index(pc, m_ghr)] >= 2 ** (CNT_W - 1);
    endfunction

    task automatic idle_inputs();
        pc = '0; opcode = '0; fetch_valid = 1'b0; update = 1'b0;
        pc_update = '0; ghr_update = '0; branch_actual = 1'b0; mispredict = 1'b0;
    endtask

    // Compare outputs against the model, then advance one clock and update the model.
    task automatic cycle(input string tag);
        bit likely;
        bit isb;
        int w;
        #1;
        likely = m_likely();
        isb    = m_is_branch(opcode);
        check({tag, ".is_branch"}, 32'(is_branch), 32'(isb));
        check({tag, ".branch_likely"}, 32'(branch_likely), 32'(likely));
        check({tag, ".pred_ghr"}, 32'(pred_ghr), 32'(m_ghr));
        check({tag, ".ready"}, 32'(ready), 32'(m_ready));
        @(posedge clk);
        if (!m_ready) begin
            m_pht[m_swept] = WNT;
            m_swept++;
            if (m_swept == DEPTH) m_ready = 1'b1;
        end else begin
            if (update) begin
                w = m_index(pc_update, int'(ghr_update));
                if (branch_actual) begin
                    if (m_pht[w] < CMAX) m_pht[w]++;
                end else if (m_pht[w] > 0) begin
                    m_pht[w]--;
                end
            end
            if (update && mispredict) m_ghr = ((int'(ghr_update) << 1) | int'(branch_actual)) & GMASK;
            else if (fetch_valid && isb) m_ghr = ((m_ghr << 1) | int'(likely)) & GMASK;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        #1;
        check("async_rst.ready", 32'(ready), 32'd0);
        check("async_rst.pred_ghr", 32'(pred_ghr), 32'd0);
        m_ghr = 0; m_swept = 0; m_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            check("rst_hold.branch_likely", 32'(branch_likely), 32'd0);
            check("rst_hold.ready", 32'(ready), 32'd0);
        end
        reset = 1'b1;
    endtask

    // Sweep with noisy update/fetch traffic, which must be ignored.
    task automatic run_sweep();
        int low;
        low = 0;
        while (ready !== 1'b1 && low < 100) begin
            opcode        = 6'h04;
            fetch_valid   = 1'b1;
            update        = 1'($urandom);
            mispredict    = update & 1'($urandom);
            pc_update     = 32'($urandom_range(0, 63)) << 2;
            ghr_update    = GHR_W'($urandom);
            branch_actual = 1'($urandom);
            pc            = 32'($urandom_range(0, 63)) << 2;
            cycle("sweep");
            low++;
        end
        check("sweep_len", 32'(low), 32'(DEPTH));
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_vec_t   dv[12];
        logic [4:0] exp_sat[5];
        logic [4:0] exp_hist[4];

        foreach (m_pht[i]) m_pht[i] = -1;
        dv[0]  = '{6'h00, 1'b0}; dv[1]  = '{6'h01, 1'b1}; dv[2]  = '{6'h02, 1'b0};
        dv[3]  = '{6'h03, 1'b0}; dv[4]  = '{6'h04, 1'b1}; dv[5]  = '{6'h05, 1'b1};
        dv[6]  = '{6'h06, 1'b1}; dv[7]  = '{6'h07, 1'b1}; dv[8]  = '{6'h08, 1'b0};
        dv[9]  = '{6'h23, 1'b0}; dv[10] = '{6'h3f, 1'b0}; dv[11] = '{6'h14, 1'b0};
        exp_sat  = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd1};
        exp_hist = '{5'b00000, 5'b00001, 5'b00011, 5'b00111};

        reset = 1'b1;
        idle_inputs();
        opcode = 6'h04;
        fetch_valid = 1'b1;
        #2;
        apply_reset(3);
        run_sweep();

        // Decode table; is_branch is pure decode.
        for (int i = 0; i < 12; i++) begin
            opcode = dv[i].op;
            #1;
            check("decode", 32'(is_branch), 32'(dv[i].isb));
            cycle("decode");
        end

        // Saturation on entry 16; the read in the update cycle sees the pre-write value.
        pc = 32'h40; opcode = 6'h04; update = 1'b1; pc_update = 32'h40;
        for (int i = 0; i < 5; i++) begin
            branch_actual = (i < 3);
            #1;
            check("sat_pre", 32'(branch_likely), 32'(exp_sat[i]));
            cycle("sat");
        end
        update = 1'b0;
        #1;
        check("sat_final", 32'(branch_likely), 32'd0);
        cycle("sat_final");

        // Not-taken predictions shift zeros into the history.
        pc = 32'h100; opcode = 6'h05; fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hist_nt", 32'(pred_ghr), 32'd0);
            cycle("hist_nt");
        end
        fetch_valid = 1'b0; update = 1'b1; branch_actual = 1'b1; ghr_update = '0;
        for (int i = 0; i < 8; i++) begin
            pc_update = 32'(i / 2) << 2;
            cycle("train");
        end
        update = 1'b0; fetch_valid = 1'b1; pc = 32'h100; opcode = 6'h05;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hist_t", 32'(pred_ghr), 32'(exp_hist[i]));
            cycle("hist_t");
        end

        // Repair, then repair racing a speculative shift.
        idle_inputs();
        update = 1'b1; mispredict = 1'b1; ghr_update = 5'b01011; pc_update = 32'h200;
        cycle("repair_setup");
        #1;
        check("repair_setup", 32'(pred_ghr), 32'b10110);
        ghr_update = 5'b00011; branch_actual = 1'b1;
        fetch_valid = 1'b1; opcode = 6'h04; pc = 32'h100;
        cycle("repair_prio");
        #1;
        check("repair_prio", 32'(pred_ghr), 32'b00111);

        // Non-branch fetch leaves history alone.
        update = 1'b0; mispredict = 1'b0; opcode = 6'h23;
        #1;
        check("nonbr.is_branch", 32'(is_branch), 32'd0);
        check("nonbr.branch_likely", 32'(branch_likely), 32'd0);
        cycle("nonbr");
        #1;
        check("nonbr.ghr", 32'(pred_ghr), 32'b00111);

        for (int i = 0; i < 400; i++) begin
            pc            = 32'($urandom_range(0, 63)) << 2;
            opcode        = ($urandom % 2 == 0) ? 6'($urandom_range(4, 7)) : 6'($urandom);
            fetch_valid   = ($urandom % 4) != 0;
            update        = 1'($urandom);
            pc_update     = 32'($urandom_range(0, 63)) << 2;
            ghr_update    = GHR_W'($urandom);
            branch_actual = 1'($urandom);
            mispredict    = update & 1'($urandom);
            cycle("rand");
        end

        // Reset in the middle of a run.
        idle_inputs();
        update = 1'b1; mispredict = 1'b1; ghr_update = 5'b01111; branch_actual = 1'b1;
        cycle("ghr_ones");
        idle_inputs();
        #1;
        check("pre_rst.pred_ghr", 32'(pred_ghr), 32'b11111);
        check("pre_rst.ready", 32'(ready), 32'd1);
        #2;
        apply_reset(2);
        run_sweep();

        // Every entry must be exactly WNT: reads not-taken, one taken step flips it.
        for (int i = 0; i < DEPTH; i++) begin
            pc = 32'(i) << 2; opcode = 6'h04;
            update = 1'b1; branch_actual = 1'b1; pc_update = 32'(i) << 2; ghr_update = '0;
            #1;
            check("wnt", 32'(branch_likely), 32'd0);
            cycle("wnt");
            #1;
            check("wnt_step", 32'(branch_likely), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
